// File: rtl/prbs_rx_checker.sv
// prbs_rx_checker
// Receive-side checker for the 48-bit PRBS link stream: a start pattern is
// followed by two concatenated 24-bit LFSR words ({upper, lower}). The block
// hunts for the start pattern, then steps local LFSRs in lockstep and compares
// every received word against them.
//
// Ports:
//   CLK, RST_N      clock (rising edge) and asynchronous active-low reset
//   DIN[47:0]       received word, one per cycle
//   LAT_START       transmitter latency-start pulse
//   CLR_CNT         synchronous clear of counters and latency result
//   LOCKED          high while locked to the stream
//   ERR             one-cycle pulse per mismatched word (registered)
//   BIT_ERR_CNT     saturating count of mismatched bits
//   WORD_ERR_CNT    saturating count of mismatched words
//   WORD_CNT        saturating count of words compared while locked
//   LATENCY         cycles from LAT_START to start pattern (saturating)
//   LAT_VALID       LATENCY holds a measurement
//
// Optional build macro PRBS_RX_ERR_CAPTURE_EN adds ERR_CAPT[47:0] and
// ERR_CAPT_VALID: the XOR pattern of the first errored word since reset or
// CLR_CNT.
module prbs_rx_checker #(
    parameter logic [47:0] START_PATTERN = 48'hFFFFFF000000,
    parameter logic [23:0] INIT_A        = 24'h83B62E,
    parameter logic [23:0] INIT_B        = 24'hE26B38,
    parameter int unsigned LOSS_THRESH   = 4,
    parameter int unsigned LAT_WIDTH     = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [47:0]          DIN,
    input  logic                 LAT_START,
    input  logic                 CLR_CNT,
    output logic                 LOCKED,
    output logic                 ERR,
    output logic [31:0]          BIT_ERR_CNT,
    output logic [31:0]          WORD_ERR_CNT,
    output logic [31:0]          WORD_CNT,
    output logic [LAT_WIDTH-1:0] LATENCY,
`ifdef PRBS_RX_ERR_CAPTURE_EN
    output logic [47:0]          ERR_CAPT,
    output logic                 ERR_CAPT_VALID,
`endif
    output logic                 LAT_VALID
);

    typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [23:0]          lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
    logic [3:0]           cons_q, cons_d;
    logic                 err_q, err_d;
    logic [31:0]          bit_cnt_q, bit_cnt_d;
    logic [31:0]          werr_cnt_q, werr_cnt_d;
    logic [31:0]          word_cnt_q, word_cnt_d;
    logic                 lat_run_q, lat_run_d;
    logic [LAT_WIDTH-1:0] lat_cnt_q, lat_cnt_d;
    logic [LAT_WIDTH-1:0] latency_q, latency_d;
    logic                 lat_valid_q, lat_valid_d;
    logic [47:0]          capt_q, capt_d;
    logic                 capt_valid_q, capt_valid_d;

    logic                 is_pat;
    logic [47:0]          diff;
    logic [4:0]           cons_inc;
    logic [32:0]          bit_sum;

    function automatic logic [23:0] lfsr_step(input logic [23:0] q);
        return {q[22:0], q[23] ^ q[22] ^ q[21] ^ q[16]};
    endfunction

    function automatic logic [5:0] popcount48(input logic [47:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 48; i++) c = c + {5'd0, v[i]};
        return c;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    assign is_pat   = (DIN == START_PATTERN);
    assign diff     = DIN ^ {lfsr_a_q, lfsr_b_q};
    assign cons_inc = {1'b0, cons_q} + 5'd1;
    // 33-bit sum so a carry out means the count would wrap -> saturate.
    assign bit_sum  = {1'b0, bit_cnt_q} + {27'd0, popcount48(diff)};

    always_comb begin
        state_d      = state_q;
        lfsr_a_d     = lfsr_a_q;
        lfsr_b_d     = lfsr_b_q;
        cons_d       = cons_q;
        err_d        = 1'b0;
        bit_cnt_d    = bit_cnt_q;
        werr_cnt_d   = werr_cnt_q;
        word_cnt_d   = word_cnt_q;
        lat_run_d    = lat_run_q;
        lat_cnt_d    = lat_cnt_q;
        latency_d    = latency_q;
        lat_valid_d  = lat_valid_q;
        capt_d       = capt_q;
        capt_valid_d = capt_valid_q;

        case (state_q)
            ST_SEARCH: begin
                // LFSRs already sit at their seeds here.
                if (is_pat) state_d = ST_LOCKED;
            end
            default: begin
                if (is_pat) begin
                    // Resync: start pattern restarts the sequence, nothing compared.
                    lfsr_a_d = INIT_A;
                    lfsr_b_d = INIT_B;
                    cons_d   = '0;
                end else begin
                    word_cnt_d = sat_inc(word_cnt_q);
                    lfsr_a_d   = lfsr_step(lfsr_a_q);
                    lfsr_b_d   = lfsr_step(lfsr_b_q);
                    if (diff != '0) begin
                        err_d      = 1'b1;
                        werr_cnt_d = sat_inc(werr_cnt_q);
                        bit_cnt_d  = bit_sum[32] ? '1 : bit_sum[31:0];
                        if (cons_inc >= 5'(LOSS_THRESH)) begin
                            state_d  = ST_SEARCH;
                            cons_d   = '0;
                            lfsr_a_d = INIT_A;
                            lfsr_b_d = INIT_B;
                        end else begin
                            cons_d = cons_inc[3:0];
                        end
                    end else begin
                        cons_d = '0;
                    end
                end
            end
        endcase

        if (err_d && !capt_valid_q) begin
            capt_d       = diff;
            capt_valid_d = 1'b1;
        end

        // lat_cnt holds (cycles since LAT_START edge) so the pattern edge
        // latches it directly; it starts at 1 on the edge after LAT_START.
        if (LAT_START) begin
            lat_valid_d = 1'b0;
            if (is_pat) begin
                latency_d   = '0;
                lat_valid_d = 1'b1;
                lat_run_d   = 1'b0;
            end else begin
                lat_run_d = 1'b1;
                lat_cnt_d = LAT_WIDTH'(1);
            end
        end else if (lat_run_q && is_pat) begin
            latency_d   = lat_cnt_q;
            lat_valid_d = 1'b1;
            lat_run_d   = 1'b0;
        end else if (lat_run_q && (lat_cnt_q != '1)) begin
            lat_cnt_d = lat_cnt_q + LAT_WIDTH'(1);
        end

        if (CLR_CNT) begin
            bit_cnt_d    = '0;
            werr_cnt_d   = '0;
            word_cnt_d   = '0;
            latency_d    = '0;
            lat_valid_d  = 1'b0;
            capt_d       = '0;
            capt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_SEARCH;
            lfsr_a_q     <= INIT_A;
            lfsr_b_q     <= INIT_B;
            cons_q       <= '0;
            err_q        <= 1'b0;
            bit_cnt_q    <= '0;
            werr_cnt_q   <= '0;
            word_cnt_q   <= '0;
            lat_run_q    <= 1'b0;
            lat_cnt_q    <= '0;
            latency_q    <= '0;
            lat_valid_q  <= 1'b0;
            capt_q       <= '0;
            capt_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_a_q     <= lfsr_a_d;
            lfsr_b_q     <= lfsr_b_d;
            cons_q       <= cons_d;
            err_q        <= err_d;
            bit_cnt_q    <= bit_cnt_d;
            werr_cnt_q   <= werr_cnt_d;
            word_cnt_q   <= word_cnt_d;
            lat_run_q    <= lat_run_d;
            lat_cnt_q    <= lat_cnt_d;
            latency_q    <= latency_d;
            lat_valid_q  <= lat_valid_d;
            capt_q       <= capt_d;
            capt_valid_q <= capt_valid_d;
        end
    end

    assign LOCKED       = (state_q == ST_LOCKED);
    assign ERR          = err_q;
    assign BIT_ERR_CNT  = bit_cnt_q;
    assign WORD_ERR_CNT = werr_cnt_q;
    assign WORD_CNT     = word_cnt_q;
    assign LATENCY      = latency_q;
    assign LAT_VALID    = lat_valid_q;
`ifdef PRBS_RX_ERR_CAPTURE_EN
    assign ERR_CAPT       = capt_q;
    assign ERR_CAPT_VALID = capt_valid_q;
`else
    // Capture state is unused in this build; fold it into a dead sink.
    logic unused_capt;
    assign unused_capt = ^{capt_q, capt_valid_q};
`endif

endmodule

// File: doc/prbs_rx_checker.md
Name: prbs_rx_checker

Overview:
- Receive-side checker for the 48-bit PRBS link stream produced by the PRBS transmitter (start pattern followed by two concatenated 24-bit LFSR words).
- Hunts for the start pattern, then runs local LFSRs in lockstep and compares every received word.
- Reports lock status, per-word error flag, saturating bit/word error counts and link latency measured from the transmitter's STRT_LTNCY pulse.
- Sits at the receiving end of the serial-link self-test path, feeding status registers.

Parameters:
- START_PATTERN, 48'hFFFFFF000000, sync word marking stream start.
- INIT_A, 24'h83B62E, seed of upper LFSR (DIN[47:24]).
- INIT_B, 24'hE26B38, seed of lower LFSR (DIN[23:0]).
- LOSS_THRESH, 4, consecutive errored words that drop lock (range 1..15).
- LAT_WIDTH, 16, width of latency counter.

Ports:
- CLK  input  1  single clock; all state on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- DIN  input  48  received word, one per cycle.
- LAT_START  input  1  pulse, the transmitter's STRT_LTNCY; starts latency measurement.
- CLR_CNT  input  1  synchronous clear of error/word counters and latency result.
- LOCKED  output  1  high while in LOCKED state.
- ERR  output  1  one-cycle pulse per mismatched word.
- BIT_ERR_CNT  output  32  total mismatched bits, saturating.
- WORD_ERR_CNT  output  32  total mismatched words, saturating.
- WORD_CNT  output  32  words compared while locked, saturating.
- LATENCY  output  LAT_WIDTH  measured latency in CLK cycles.
- LAT_VALID  output  1  LATENCY holds a valid measurement.

Behaviour:
- Reset (RST_N low, immediate): all outputs and counters 0, state SEARCH, LFSRs hold INIT_A/INIT_B, latency counter idle.
- LFSR step, identical to the transmit generator ([24,23,22,17] Fibonacci): next = {q[22:0], q[23]^q[22]^q[21]^q[16]}. Expected word EXP = {lfsr_a, lfsr_b}.
- SEARCH: LFSRs held at seeds; no compare, no counting. DIN==START_PATTERN sampled at edge n: go to LOCKED at edge n; LOCKED=1 after edge n.
- LOCKED: at each edge, X = DIN ^ EXP. If DIN==START_PATTERN: resync (reload seeds, clear consecutive-error count, no compare, no count). Otherwise: WORD_CNT+1; if X!=0 then ERR=1, WORD_ERR_CNT+1, BIT_ERR_CNT += popcount(X) (0..48), consecutive-error count +1, else ERR=0 and consecutive count cleared. LFSRs advance one step after every compare. First compared word after start pattern must equal {INIT_A,INIT_B}.
- Loss of lock: consecutive count reaching LOSS_THRESH returns to SEARCH at that same edge; LOCKED=0 after it; ERR still pulses for that word. Counters are not cleared on loss.
- ERR registered, 1-cycle latency from DIN; de-asserted in SEARCH.
- Counters saturate at 32'hFFFFFFFF; BIT_ERR_CNT saturates instead of wrapping when the addition overflows.
- CLR_CNT: clears BIT_ERR_CNT, WORD_ERR_CNT, WORD_CNT, LATENCY, LAT_VALID; has priority over same-cycle increments; does not affect state or LFSRs.
- Latency: LAT_START sampled at edge n, START_PATTERN sampled at edge m>=n (any state) → LATENCY = m-n, LAT_VALID=1 at edge m. Same-edge → 0. New LAT_START while running restarts count. Counter saturates at all-ones; measurement stays running until pattern seen. LAT_VALID persists until CLR_CNT or new LAT_START (new LAT_START clears LAT_VALID).
- A legal PRBS word equal to START_PATTERN is treated as resync; accepted.

Optional Feature:
- Macro PRBS_RX_ERR_CAPTURE_EN. Defined: adds outputs ERR_CAPT (48) and ERR_CAPT_VALID (1); on first errored word since reset/CLR_CNT, ERR_CAPT latches X and ERR_CAPT_VALID=1; later errors do not overwrite; CLR_CNT clears both. Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: RST_N low mid-stream → all outputs 0 immediately, LOCKED=0; release, no start pattern for 50 cycles → counts stay 0.
- Clean lock: start pattern then 1000 model words → LOCKED=1 after pattern edge, WORD_CNT=1000, ERR never high, error counts 0.
- Single injected error: word 10 XOR 48'h608000400100 → ERR one pulse, BIT_ERR_CNT=5, WORD_ERR_CNT=1, LOCKED stays 1.
- Loss/relock: 4 consecutive corrupted words → LOCKED=0 after 4th, WORD_ERR_CNT=4; start pattern again → relock, next 100 words clean.
- Latency: LAT_START pulse, start pattern 3 cycles later → LATENCY=3, LAT_VALID=1; CLR_CNT → 0/0.
- Saturation/clear: force WORD_ERR_CNT near max (long bad stream, lock threshold 15 with resyncs) → holds 32'hFFFFFFFF; CLR_CNT coincident with an error → counter reads 0.
